// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Holds the FSM state encoding and the default operand/digit widths.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIGIT = 1;

endpackage

// File: rtl/serial_adder_digit.sv
// DIGIT-bit ripple adder built from 1-bit full-adder equations.
// Also exposes the carry into its top bit so the parent can derive signed overflow.
module full_adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [DIGIT:0] carry;

    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = c_i;
        for (int i = 0; i < DIGIT; i++) begin
            s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = carry[DIGIT];
    assign c_msb_o = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB first,
// and publishes sum/cout/overflow only on the final edge of each operation.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_badParams
        $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] digSum;
    logic             digCout;
    logic             digCmsb;

    full_adder_digit #(.DIGIT(DIGIT)) u_digit (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .c_i     (carry_q),
        .s_o     (digSum),
        .c_o     (digCout),
        .c_msb_o (digCmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Subtraction is a + ~b + ~borrow; the shift register fills from the MSB end
    // so the word is aligned after N steps and only then copied to the outputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = (acc_q >> DIGIT) | (WIDTH'(digSum) << (WIDTH - DIGIT));
                carry_d = digCout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = acc_d;
                    cout_d  = digCout;
                    ovf_d   = digCmsb ^ digCout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits added per clock; SHALL divide WIDTH exactly (elaboration error otherwise).
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin one operation.
REQ-006 sub  input  1  mode select: 0 = a+b+cin, 1 = a-b-cin.
REQ-007 a  input  WIDTH  first operand, sampled only on an accepted start.
REQ-008 b  input  WIDTH  second operand, sampled only on an accepted start.
REQ-009 cin  input  1  carry-in (add) or borrow-in (sub), sampled only on an accepted start.
REQ-010 sum  output  WIDTH  result word.
REQ-011 cout  output  1  final carry; in sub mode 1 = no borrow, 0 = borrow.
REQ-012 overflow  output  1  two's-complement signed overflow of the result.
REQ-013 busy  output  1  operation in progress.
REQ-014 done  output  1  one-cycle pulse: result valid.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-016 start SHALL be accepted on a rising edge only when state is IDLE or DONE; otherwise ignored.
REQ-017 On acceptance: latch a; latch b (sub=0) or ~b (sub=1); carry register = cin (sub=0) or ~cin (sub=1); step counter = 0; go to RUN.
REQ-018 In RUN, each edge SHALL add the DIGIT least-significant bits of both operand registers plus carry, shift the DIGIT result bits into sum from the MSB end, shift operands right by DIGIT, update carry, increment counter.
REQ-019 After the Nth RUN edge, state SHALL be DONE; cout = final carry; overflow = carry into MSB XOR carry out of MSB.
REQ-020 Latency: start accepted at edge k -> done = 1 during the cycle following edge k+N exactly.
REQ-021 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; DONE -> IDLE after one cycle unless start is accepted (then -> RUN).
REQ-022 sum, cout, overflow SHALL hold their last completed values in IDLE/DONE until the next operation's final edge; in RUN they are undefined to consumers.
REQ-023 Changes on a, b, sub, cin during RUN SHALL NOT affect the operation in flight.
REQ-024 Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, sum = 0, cout = 0, overflow = 0, busy = 0, done = 0, counter = 0, carry = 0.
REQ-026 Reset asserted during RUN SHALL abort the operation with no done pulse; first start after release SHALL be accepted normally.

Structure
REQ-027 FSM state encoding and the default WIDTH/DIGIT constants SHALL live in shared package serial_adder_pkg.
REQ-028 Digit datapath SHALL be one sub-module full_adder_digit (DIGIT-bit ripple of 1-bit full-adder equations: sum = a^b^c, carry = ab|c(a^b)), exposing carry into its MSB for overflow.

Verification (WIDTH=8 unless noted)
REQ-029 Reset, then start with a=0x00, b=0x00, cin=0, sub=0 -> done exactly 8 cycles after start edge, sum=0x00, cout=0, overflow=0.
REQ-030 a=0xFF, b=0x01, cin=1, sub=0 -> sum=0x01, cout=1, overflow=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1.
REQ-031 sub=1, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0 (borrow), overflow=0; a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
REQ-032 start pulsed again 3 cycles into RUN with different operands -> ignored, first result unchanged, single done pulse; start held high through DONE -> back-to-back operation, next done 8 cycles later.
REQ-033 rst_n driven low 4 cycles into RUN -> all outputs 0 asynchronously, no done; next start after release yields correct result.
REQ-034 WIDTH=16, DIGIT=4: a=0x1234, b=0xEDCC, cin=0 -> done 4 cycles after start, sum=0x0000, cout=1, overflow=0.
